// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
// Optional address checking is enabled by defining MEM_RESPONDER_ERRCHK_EN.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int          BANK_SEL_BIT  = 28;
    localparam logic [31:0] UNMAPPED_MASK = 32'hE000_0000;

    // Misaligned word access or anything outside the two mapped banks.
    function automatic logic addr_error(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr & UNMAPPED_MASK) != 32'h0);
    endfunction

endpackage

// File: rtl/mem_responder_bank.sv
// Byte-enabled synchronous single-port RAM, 32-bit words, 2**ADDR_W deep.
// The read register only updates on enabled reads, so it holds across writes.
module mem_responder_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              iCLK,
    input  logic              iEn,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWData,
    input  logic [3:0]        iBE,
    output logic [31:0]       oRData
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // NOTE: the array and its read register have no reset so they map onto block RAM;
    // contents must survive a responder reset anyway.
    always_ff @(posedge iCLK) begin
        if (iEn) begin
            if (iWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (iBE[b]) begin
                        r_mem[iAddr][8*b +: 8] <= iWData[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[iAddr];
            end
        end
    end

    assign oRData = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Req/ack memory responder steering word accesses to a text or data bank.
// Define MEM_RESPONDER_ERRCHK_EN to flag misaligned and unmapped addresses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [3:0]  iBE,
    output logic [31:0] oRData,
    output logic        oAck,
    output logic        oErr,
    output logic        oBusy
);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_wait_cnt;
    logic                r_we;
    logic                r_bank;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_rdata_zero;
    logic                r_rdata_bank;
    logic                w_accept;
    logic                w_access;
    logic [31:0]         w_text_rdata;
    logic [31:0]         w_data_rdata;
    logic                w_unused_addr;

    assign w_accept      = (r_state == IDLE) && iReq;
    assign w_access      = (r_state == ACCESS);
    assign w_unused_addr = ^iAddr;

`ifdef MEM_RESPONDER_ERRCHK_EN
    logic w_addr_err;
    logic r_err;
    assign w_addr_err = addr_error(iAddr);
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (iReq) begin
`ifdef MEM_RESPONDER_ERRCHK_EN
                    if (w_addr_err) begin
                        w_next_state = RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        w_next_state = WAIT;
                    end else begin
                        w_next_state = ACCESS;
                    end
`else
                    if (WAIT_CYCLES > 0) begin
                        w_next_state = WAIT;
                    end else begin
                        w_next_state = ACCESS;
                    end
`endif
                end
            end
            WAIT:    if (r_wait_cnt == 4'd0) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_wait_cnt   <= 4'd0;
            r_we         <= 1'b0;
            r_bank       <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 32'h0;
            r_be         <= 4'h0;
            r_rdata_zero <= 1'b1;
            r_rdata_bank <= 1'b0;
`ifdef MEM_RESPONDER_ERRCHK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_we    <= iWe;
                r_bank  <= iAddr[BANK_SEL_BIT];
                r_idx   <= iAddr[ADDR_W+1:2];
                r_wdata <= iWData;
                r_be    <= iBE;
                if (WAIT_CYCLES > 0) begin
                    r_wait_cnt <= 4'(WAIT_CYCLES - 1);
                end
`ifdef MEM_RESPONDER_ERRCHK_EN
                r_err <= w_addr_err;
                if (w_addr_err) begin
                    r_rdata_zero <= 1'b1;
                end
`endif
            end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            // Remember which bank owns the read register; writes leave oRData alone.
            if (w_access && !r_we) begin
                r_rdata_zero <= 1'b0;
                r_rdata_bank <= r_bank;
            end
        end
    end

    mem_responder_bank #(.ADDR_W(ADDR_W)) u_text_bank (
        .iCLK   (iCLK),
        .iEn    (w_access && !r_bank),
        .iWe    (r_we),
        .iAddr  (r_idx),
        .iWData (r_wdata),
        .iBE    (r_be),
        .oRData (w_text_rdata)
    );

    mem_responder_bank #(.ADDR_W(ADDR_W)) u_data_bank (
        .iCLK   (iCLK),
        .iEn    (w_access && r_bank),
        .iWe    (r_we),
        .iAddr  (r_idx),
        .iWData (r_wdata),
        .iBE    (r_be),
        .oRData (w_data_rdata)
    );

    assign oRData = r_rdata_zero ? 32'h0 : (r_rdata_bank ? w_data_rdata : w_text_rdata);
    assign oAck   = (r_state == RESP);
    assign oBusy  = (r_state != IDLE);
`ifdef MEM_RESPONDER_ERRCHK_EN
    assign oErr   = r_err && (r_state == RESP);
`else
    assign oErr   = 1'b0;
`endif

endmodule
